// File: rtl/lsu_mm_issue_if.sv
// Bundled command, buffer-control, RAM-read and alloc-return signals of lsu_mm_issue.
// Valid/ready rule: cmd transfers on a rising edge where cmd_vld && cmd_rdy; the master holds fields stable while cmd_vld is high.
interface lsu_mm_issue_if;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [11:0]  cmd_i_addr;
  logic [11:0]  cmd_w_addr;
  logic [3:0]   cmd_m_len;
  logic [3:0]   cmd_n_len;
  logic [3:0]   cmd_k_len;

  logic         i_ctrl_vld;
  logic [3:0]   i_row_len;
  logic [3:0]   i_col_len;
  logic [11:0]  i_start_addr;
  logic         i_ram_type;
  logic         w_ctrl_vld;
  logic [3:0]   w_row_len;
  logic [3:0]   w_col_len;
  logic [11:0]  w_start_addr;
  logic         w_ram_type;

  logic         i_rd_vld;
  logic [7:0]   i_rd_addr;
  logic         w_rd_vld;
  logic [7:0]   w_rd_addr;

  logic         iram_rd_en;
  logic [7:0]   iram_rd_addr;
  logic [127:0] iram_rdata;
  logic         wram_rd_en;
  logic [7:0]   wram_rd_addr;
  logic [127:0] wram_rdata;

  logic         i_alloc_vld;
  logic [7:0]   i_alloc_addr;
  logic [127:0] i_alloc_data;
  logic         w_alloc_vld;
  logic [7:0]   w_alloc_addr;
  logic [127:0] w_alloc_data;

  logic         i_end;
  logic         w_end;
  logic         done;
  logic         busy;
  logic         err;
  logic [1:0]   state_dbg;

  modport slave (
    input  cmd_vld, cmd_i_addr, cmd_w_addr, cmd_m_len, cmd_n_len, cmd_k_len,
    input  i_rd_vld, i_rd_addr, w_rd_vld, w_rd_addr,
    input  iram_rdata, wram_rdata, i_end, w_end,
    output cmd_rdy,
    output i_ctrl_vld, i_row_len, i_col_len, i_start_addr, i_ram_type,
    output w_ctrl_vld, w_row_len, w_col_len, w_start_addr, w_ram_type,
    output iram_rd_en, iram_rd_addr, wram_rd_en, wram_rd_addr,
    output i_alloc_vld, i_alloc_addr, i_alloc_data,
    output w_alloc_vld, w_alloc_addr, w_alloc_data,
    output done, busy, err, state_dbg
  );

  modport master (
    output cmd_vld, cmd_i_addr, cmd_w_addr, cmd_m_len, cmd_n_len, cmd_k_len,
    output i_rd_vld, i_rd_addr, w_rd_vld, w_rd_addr,
    output iram_rdata, wram_rdata, i_end, w_end,
    input  cmd_rdy,
    input  i_ctrl_vld, i_row_len, i_col_len, i_start_addr, i_ram_type,
    input  w_ctrl_vld, w_row_len, w_col_len, w_start_addr, w_ram_type,
    input  iram_rd_en, iram_rd_addr, wram_rd_en, wram_rd_addr,
    input  i_alloc_vld, i_alloc_addr, i_alloc_data,
    input  w_alloc_vld, w_alloc_addr, w_alloc_data,
    input  done, busy, err, state_dbg
  );
endinterface

// File: rtl/lsu_mm_issue.sv
// Matmul issue unit: latches a command, drives iram/wram buffer control until both buffers end, and forwards buffer reads to the RAMs.
// Optional watchdog enabled by defining LSU_MM_ISSUE_TIMEOUT_EN.
module lsu_mm_issue (
  input logic           clk,
  input logic           rst,
  lsu_mm_issue_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  m_len_q, m_len_d;
  logic [3:0]  n_len_q, n_len_d;
  logic [3:0]  k_len_q, k_len_d;
  logic [11:0] i_addr_q, i_addr_d;
  logic [11:0] w_addr_q, w_addr_d;
  logic        i_seen_q, i_seen_d;
  logic        w_seen_q, w_seen_d;
  logic        done_q, done_d;
  logic        i_alloc_vld_q, i_alloc_vld_d;
  logic [7:0]  i_alloc_addr_q, i_alloc_addr_d;
  logic        w_alloc_vld_q, w_alloc_vld_d;
  logic [7:0]  w_alloc_addr_q, w_alloc_addr_d;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
`endif

  logic accept;
  logic complete;

  assign accept   = bus.cmd_vld && (state_q == ST_IDLE);
  // An end flag seen in an earlier RUN cycle counts the same as one arriving now.
  assign complete = (i_seen_q | bus.i_end) & (w_seen_q | bus.w_end);

  always_comb begin
    state_d  = state_q;
    m_len_d  = m_len_q;
    n_len_d  = n_len_q;
    k_len_d  = k_len_q;
    i_addr_d = i_addr_q;
    w_addr_d = w_addr_q;
    i_seen_d = i_seen_q;
    w_seen_d = w_seen_q;
    done_d   = 1'b0;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          m_len_d  = bus.cmd_m_len;
          n_len_d  = bus.cmd_n_len;
          k_len_d  = bus.cmd_k_len;
          i_addr_d = bus.cmd_i_addr;
          w_addr_d = bus.cmd_w_addr;
          i_seen_d = 1'b0;
          w_seen_d = 1'b0;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
          wd_cnt_d = 8'd0;
`endif
        end
      end
      ST_RUN: begin
        i_seen_d = i_seen_q | bus.i_end;
        w_seen_d = w_seen_q | bus.w_end;
        if (complete) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
        else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
          // Abort without a done pulse once the run has lasted 255 cycles.
          if (wd_cnt_d == 8'd255) begin
            state_d = ST_GAP;
            err_d   = 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    i_alloc_vld_d  = bus.i_rd_vld;
    i_alloc_addr_d = bus.i_rd_addr;
    w_alloc_vld_d  = bus.w_rd_vld;
    w_alloc_addr_d = bus.w_rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      m_len_q        <= 4'd0;
      n_len_q        <= 4'd0;
      k_len_q        <= 4'd0;
      i_addr_q       <= 12'd0;
      w_addr_q       <= 12'd0;
      i_seen_q       <= 1'b0;
      w_seen_q       <= 1'b0;
      done_q         <= 1'b0;
      i_alloc_vld_q  <= 1'b0;
      i_alloc_addr_q <= 8'd0;
      w_alloc_vld_q  <= 1'b0;
      w_alloc_addr_q <= 8'd0;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
      wd_cnt_q       <= 8'd0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      m_len_q        <= m_len_d;
      n_len_q        <= n_len_d;
      k_len_q        <= k_len_d;
      i_addr_q       <= i_addr_d;
      w_addr_q       <= w_addr_d;
      i_seen_q       <= i_seen_d;
      w_seen_q       <= w_seen_d;
      done_q         <= done_d;
      i_alloc_vld_q  <= i_alloc_vld_d;
      i_alloc_addr_q <= i_alloc_addr_d;
      w_alloc_vld_q  <= w_alloc_vld_d;
      w_alloc_addr_q <= w_alloc_addr_d;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
      wd_cnt_q       <= wd_cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign bus.cmd_rdy      = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.state_dbg    = state_q;
`ifdef LSU_MM_ISSUE_TIMEOUT_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

  assign bus.i_ctrl_vld   = (state_q == ST_RUN);
  assign bus.i_row_len    = m_len_q;
  assign bus.i_col_len    = k_len_q;
  assign bus.i_start_addr = i_addr_q;
  assign bus.i_ram_type   = 1'b1;

  assign bus.w_ctrl_vld   = (state_q == ST_RUN);
  assign bus.w_row_len    = n_len_q;
  assign bus.w_col_len    = k_len_q;
  assign bus.w_start_addr = w_addr_q;
  assign bus.w_ram_type   = 1'b0;

  // Reads pass straight through regardless of state; the RAM answers one cycle later, aligned with the registered alloc_vld.
  assign bus.iram_rd_en   = bus.i_rd_vld;
  assign bus.iram_rd_addr = bus.i_rd_addr;
  assign bus.wram_rd_en   = bus.w_rd_vld;
  assign bus.wram_rd_addr = bus.w_rd_addr;

  assign bus.i_alloc_vld  = i_alloc_vld_q;
  assign bus.i_alloc_addr = i_alloc_addr_q;
  assign bus.i_alloc_data = bus.iram_rdata;
  assign bus.w_alloc_vld  = w_alloc_vld_q;
  assign bus.w_alloc_addr = w_alloc_addr_q;
  assign bus.w_alloc_data = bus.wram_rdata;

endmodule
